dense_mac_q88: RTL and testbench
================================

DENSE_MAC_Q88 -- requirements
Module: dense_mac_q88

Interface
REQ-001 SHALL have parameter N_IN, default 8, meaning the number of x*w products per output (legal range 2..256).
REQ-002 SHALL have port clk  input  1  meaning the single rising-edge clock for all state.
REQ-003 SHALL have port rst_n  input  1  meaning the asynchronous, active-low reset.
REQ-004 SHALL have port start  input  1  meaning a pulse that begins one dot-product (sampled in IDLE only).
REQ-005 SHALL have port in_valid  input  1  meaning x_in/w_in carry a valid beat.
REQ-006 SHALL have port in_ready  output  1  meaning the block accepts a beat this cycle.
REQ-007 SHALL have port x_in  input  16 signed  meaning the activation in Q8.8.
REQ-008 SHALL have port w_in  input  16 signed  meaning the weight in Q8.8.
REQ-009 SHALL have port bias  input  16 signed  meaning the bias in Q8.8, sampled in FIN.
REQ-010 SHALL have port out_valid  output  1  meaning a single-cycle result pulse, wired to the sigmoid stage's valid_in.
REQ-011 SHALL have port y_out  output  16 signed  meaning the pre-activation in Q8.8, wired to the sigmoid stage's x_in.
REQ-012 SHALL have port ovf  output  1  meaning the current result exceeded the Q8.8 range; valid only with out_valid.
REQ-013 SHALL have port busy  output  1  meaning the state is not IDLE.

Function
REQ-014 SHALL implement the states IDLE, ACC and FIN; busy SHALL be 1 in ACC and FIN.
REQ-015 IDLE: start=1 SHALL clear the 40-bit signed accumulator and the beat counter, then go to ACC; start SHALL be ignored in ACC and FIN.
REQ-016 in_ready SHALL be 1 exactly when the state is ACC; a beat is accepted on a rising edge where in_valid and in_ready are both 1.
REQ-017 Each accepted beat SHALL add the full 32-bit signed product x_in*w_in (Q16.16), sign-extended to 40 bits, to the accumulator and increment the counter.
REQ-018 Gaps in in_valid SHALL stall accumulation without changing the accumulator or the counter.
REQ-019 On acceptance of beat N_IN the state SHALL go to FIN; no further beats are accepted.
REQ-020 FIN (one cycle) SHALL compute s = acc + (sign-extended bias << 8) and r = s >>> 8 (arithmetic shift, floor rounding), then go to IDLE.
REQ-021 On the FIN edge, ovf SHALL be loaded with 1 if r < -32768 or r > 32767, else 0; y_out SHALL be loaded per REQ-029/030; out_valid SHALL be set to 1.
REQ-022 out_valid SHALL be 1 for exactly one cycle, beginning at the second rising edge after the final beat is accepted; there is no output backpressure.
REQ-023 y_out and ovf SHALL hold their values until the next FIN.
REQ-024 start asserted in IDLE during the out_valid cycle SHALL begin a new operation normally (back-to-back throughput: N_IN+2 cycles per result).

Reset
REQ-025 rst_n=0 SHALL immediately force the state to IDLE and set out_valid=0, y_out=0, ovf=0, in_ready=0 and busy=0.
REQ-026 rst_n=0 SHALL immediately clear the accumulator and the counter.
REQ-027 Reset mid-ACC or mid-FIN SHALL discard the partial result and SHALL NOT produce an out_valid pulse.
REQ-028 After rst_n is released, the block SHALL wait in IDLE for start.

Configuration
REQ-029 With DENSE_MAC_SAT_EN defined, y_out SHALL be r clamped to [-32768, 32767].
REQ-030 Without DENSE_MAC_SAT_EN, y_out SHALL be r[15:0] (two's-complement wrap); ovf SHALL be reported identically in both builds.

Verification
REQ-031 N_IN=4, four beats x=256, w=256, bias=0 -> out_valid pulse, y_out=1024, ovf=0.
REQ-032 N_IN=4, beats x=32767, w=32767, bias=0 -> ovf=1; y_out=32767 with the macro, y_out=r[15:0] without it.
REQ-033 N_IN=2, beats (x=-1, w=1) and (x=0, w=0), bias=0 -> y_out=-1 (floor); with bias=-256 -> y_out=-257.
REQ-034 N_IN=4 with in_valid low for 3 cycles between beats 2 and 3 -> same result as the no-gap case; out_valid exactly 2 edges after the last beat; start pulses during busy are ignored.
REQ-035 rst_n pulsed low after 2 of 4 beats, then a fresh start with four beats x=256, w=512 -> no pulse from the aborted run; result y_out=2048.

Source files
------------

// File: rtl/dense_mac_q88.sv
// dense_mac_q88: streaming Q8.8 dot-product engine with bias.
// Accepts N_IN (x, w) beats, accumulates full-precision Q16.16 products in a
// 40-bit accumulator, adds bias in a one-cycle FIN state and emits a single
// out_valid pulse carrying the Q8.8 pre-activation and an overflow flag.
// Optional build macro: DENSE_MAC_SAT_EN -- clamp y_out to the Q8.8 range
// instead of wrapping. ovf is reported the same way in both builds.
module dense_mac_q88 #(
  parameter int N_IN = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic signed [15:0] x_in,
  input  logic signed [15:0] w_in,
  input  logic signed [15:0] bias,
  output logic               out_valid,
  output logic signed [15:0] y_out,
  output logic               ovf,
  output logic               busy
);

  localparam int               CW   = $clog2(N_IN + 1);
  localparam logic [CW-1:0]    LAST = CW'(N_IN - 1);
  localparam logic signed [39:0] Q_MAX = 40'sd32767;
  localparam logic signed [39:0] Q_MIN = -40'sd32768;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACC,
    S_FIN
  } state_t;

  state_t                r_state;
  logic signed [39:0]    r_acc;
  logic [CW-1:0]         r_cnt;

  logic                  w_accept;
  logic signed [31:0]    w_prod;
  logic signed [39:0]    w_prod_ext;
  logic signed [39:0]    w_bias_ext;
  logic signed [39:0]    w_sum;
  logic signed [39:0]    w_res;
  logic                  w_ovf;
  logic signed [15:0]    w_y;

  // Handshake and status decoded directly from the state register.
  assign in_ready = (r_state == S_ACC);
  assign busy     = (r_state != S_IDLE);
  assign w_accept = in_ready && in_valid;

  // Full-precision product and FIN-stage arithmetic.
  assign w_prod     = x_in * w_in;
  assign w_prod_ext = {{8{w_prod[31]}}, w_prod};
  assign w_bias_ext = {{16{bias[15]}}, bias, 8'h00};
  assign w_sum      = r_acc + w_bias_ext;
  assign w_res      = w_sum >>> 8;
  assign w_ovf      = (w_res > Q_MAX) || (w_res < Q_MIN);

  // Result formatting: clamp or two's-complement wrap.
  always_comb begin
    w_y = w_res[15:0];
`ifdef DENSE_MAC_SAT_EN
    if (w_res > Q_MAX) begin
      w_y = 16'sh7FFF;
    end else if (w_res < Q_MIN) begin
      w_y = 16'sh8000;
    end
`endif
  end

  // Control FSM, accumulator, beat counter and registered result outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_acc     <= '0;
      r_cnt     <= '0;
      out_valid <= 1'b0;
      y_out     <= '0;
      ovf       <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_acc   <= '0;
            r_cnt   <= '0;
            r_state <= S_ACC;
          end
        end
        S_ACC: begin
          if (w_accept) begin
            r_acc <= r_acc + w_prod_ext;
            r_cnt <= r_cnt + CW'(1);
            if (r_cnt == LAST) begin
              r_state <= S_FIN;
            end
          end
        end
        S_FIN: begin
          y_out     <= w_y;
          ovf       <= w_ovf;
          out_valid <= 1'b1;
          r_state   <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dense_mac_q88.sv
// Directed self-checking bench for dense_mac_q88 (N_IN=4 and N_IN=2 instances).
module tb_dense_mac_q88;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               start4, start2;
  logic               in_valid;
  logic signed [15:0] x, w, bias;

  logic               rdy4, ov4, of4, busy4;
  logic signed [15:0] y4;
  logic               rdy2, ov2, of2, busy2;
  logic signed [15:0] y2;

  logic               sel2;
  logic               ov_s, of_s;
  logic signed [15:0] y_s;

  logic signed [15:0] g_x[4];
  logic signed [15:0] g_w[4];

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;

  always #5 clk = ~clk;

  assign ov_s = sel2 ? ov2 : ov4;
  assign of_s = sel2 ? of2 : of4;
  assign y_s  = sel2 ? y2  : y4;

  dense_mac_q88 #(.N_IN(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .in_valid(in_valid),
    .in_ready(rdy4), .x_in(x), .w_in(w), .bias(bias),
    .out_valid(ov4), .y_out(y4), .ovf(of4), .busy(busy4)
  );

  dense_mac_q88 #(.N_IN(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .in_valid(in_valid),
    .in_ready(rdy2), .x_in(x), .w_in(w), .bias(bias),
    .out_valid(ov2), .y_out(y2), .ovf(of2), .busy(busy2)
  );

  task automatic tick;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic set_start(input bit use2, input logic v);
    if (use2) start2 = v;
    else      start4 = v;
  endtask

  // Drives one dot-product; returns edges from last beat to out_valid (-1 on timeout).
  task automatic run_op(input bit use2, input int n, input int gap_at, input int gap_len,
                        input bit noise, input bit no_start, input bit chain,
                        output int lat, output int t_out, output logic signed [15:0] y,
                        output logic o, output logic v_next);
    sel2 = use2;
    if (!no_start) begin
      set_start(use2, 1'b1);
      tick();
      set_start(use2, 1'b0);
    end
    for (int i = 0; i < n; i++) begin
      if (i == gap_at) begin
        for (int g = 0; g < gap_len; g++) begin
          in_valid = 1'b0;
          x = 16'sh5555;
          w = 16'sh3333;
          set_start(use2, noise && (g == 0));
          tick();
          set_start(use2, 1'b0);
        end
      end
      in_valid = 1'b1;
      x = g_x[i];
      w = g_w[i];
      tick();
    end
    in_valid = 1'b0;
    set_start(use2, noise);
    lat = -1;
    t_out = -1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      set_start(use2, 1'b0);
      if (ov_s) begin
        lat = k;
        t_out = cyc;
        break;
      end
    end
    y = y_s;
    o = of_s;
    if (chain) set_start(use2, 1'b1);
    tick();
    set_start(use2, 1'b0);
    v_next = ov_s;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #3;
    n_chk++;
    if ({ov4, y4, of4, rdy4, busy4} !== 20'h0) begin
      n_err++;
      $display("FAIL reset_n4: got ov=%b y=%0d ovf=%b rdy=%b busy=%b, want all 0", ov4, y4, of4, rdy4, busy4);
    end
    n_chk++;
    if ({ov2, y2, of2, rdy2, busy2} !== 20'h0) begin
      n_err++;
      $display("FAIL reset_n2: got ov=%b y=%0d ovf=%b rdy=%b busy=%b, want all 0", ov2, y2, of2, rdy2, busy2);
    end
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    n_chk++;
    if (busy4 !== 1'b0 || rdy4 !== 1'b0) begin
      n_err++;
      $display("FAIL idle_wait: got busy=%b rdy=%b, want 0 0", busy4, rdy4);
    end
  endtask

  task automatic test_basic;
    int lat, t;
    logic signed [15:0] y;
    logic o, vn;
    bias = 16'sd0;
    for (int i = 0; i < 4; i++) begin g_x[i] = 16'sd256; g_w[i] = 16'sd256; end
    run_op(1'b0, 4, -1, 0, 1'b0, 1'b0, 1'b0, lat, t, y, o, vn);
    n_chk++;
    if (lat !== 1) begin n_err++; $display("FAIL basic_latency: got %0d want 1", lat); end
    n_chk++;
    if (y !== 16'sd1024 || o !== 1'b0) begin n_err++; $display("FAIL basic_result: got y=%0d ovf=%b want 1024 0", y, o); end
    n_chk++;
    if (vn !== 1'b0) begin n_err++; $display("FAIL basic_pulse_width: got out_valid=%b want 0", vn); end
    for (int i = 0; i < 3; i++) tick();
    n_chk++;
    if (y4 !== 16'sd1024) begin n_err++; $display("FAIL basic_hold: got %0d want 1024", y4); end
  endtask

  task automatic test_handshake;
    sel2 = 1'b0;
    bias = 16'sd0;
    start4 = 1'b1;
    tick();
    start4 = 1'b0;
    n_chk++;
    if (busy4 !== 1'b1 || rdy4 !== 1'b1) begin n_err++; $display("FAIL hs_acc: got busy=%b rdy=%b want 1 1", busy4, rdy4); end
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; x = 16'sd512; w = -16'sd256;
      tick();
    end
    in_valid = 1'b0;
    n_chk++;
    if (busy4 !== 1'b1 || rdy4 !== 1'b0 || ov4 !== 1'b0) begin
      n_err++; $display("FAIL hs_fin: got busy=%b rdy=%b ov=%b want 1 0 0", busy4, rdy4, ov4);
    end
    tick();
    n_chk++;
    if (busy4 !== 1'b0 || ov4 !== 1'b1 || y4 !== -16'sd2048) begin
      n_err++; $display("FAIL hs_done: got busy=%b ov=%b y=%0d want 0 1 -2048", busy4, ov4, y4);
    end
    tick();
  endtask

  task automatic test_ovf_pos;
    int lat, t;
    logic signed [15:0] y, ye;
    logic o, vn;
`ifdef DENSE_MAC_SAT_EN
    ye = 16'sh7FFF;
`else
    ye = 16'shFC00;
`endif
    bias = 16'sd0;
    for (int i = 0; i < 4; i++) begin g_x[i] = 16'sd32767; g_w[i] = 16'sd32767; end
    run_op(1'b0, 4, -1, 0, 1'b0, 1'b0, 1'b0, lat, t, y, o, vn);
    n_chk++;
    if (lat !== 1 || o !== 1'b1 || y !== ye) begin
      n_err++; $display("FAIL ovf_pos: got lat=%0d ovf=%b y=%0d want 1 1 %0d", lat, o, y, ye);
    end
  endtask

  task automatic test_floor;
    int lat, t;
    logic signed [15:0] y;
    logic o, vn;
    g_x[0] = -16'sd1; g_w[0] = 16'sd1; g_x[1] = 16'sd0; g_w[1] = 16'sd0;
    bias = 16'sd0;
    run_op(1'b1, 2, -1, 0, 1'b0, 1'b0, 1'b0, lat, t, y, o, vn);
    n_chk++;
    if (lat !== 1 || y !== -16'sd1 || o !== 1'b0) begin
      n_err++; $display("FAIL floor_nobias: got lat=%0d y=%0d ovf=%b want 1 -1 0", lat, y, o);
    end
    bias = -16'sd256;
    run_op(1'b1, 2, -1, 0, 1'b0, 1'b0, 1'b0, lat, t, y, o, vn);
    n_chk++;
    if (y !== -16'sd257 || o !== 1'b0) begin
      n_err++; $display("FAIL floor_bias: got y=%0d ovf=%b want -257 0", y, o);
    end
  endtask

  task automatic test_ovf_neg;
    int lat, t;
    logic signed [15:0] y, ye;
    logic o, vn;
`ifdef DENSE_MAC_SAT_EN
    ye = 16'sh8000;
`else
    ye = 16'sd256;
`endif
    bias = 16'sd0;
    for (int i = 0; i < 2; i++) begin g_x[i] = -16'sd32768; g_w[i] = 16'sd32767; end
    run_op(1'b1, 2, -1, 0, 1'b0, 1'b0, 1'b0, lat, t, y, o, vn);
    n_chk++;
    if (o !== 1'b1 || y !== ye) begin
      n_err++; $display("FAIL ovf_neg: got ovf=%b y=%0d want 1 %0d", o, y, ye);
    end
  endtask

  task automatic test_boundary;
    int lat, t;
    logic signed [15:0] y, ye;
    logic o, vn;
    g_x[0] = 16'sd32767; g_w[0] = 16'sd256; g_x[1] = 16'sd0; g_w[1] = 16'sd7;
    bias = 16'sd0;
    run_op(1'b1, 2, -1, 0, 1'b0, 1'b0, 1'b0, lat, t, y, o, vn);
    n_chk++;
    if (y !== 16'sd32767 || o !== 1'b0) begin
      n_err++; $display("FAIL bound_max: got y=%0d ovf=%b want 32767 0", y, o);
    end
`ifdef DENSE_MAC_SAT_EN
    ye = 16'sh7FFF;
`else
    ye = 16'sh8000;
`endif
    bias = 16'sd1;
    run_op(1'b1, 2, -1, 0, 1'b0, 1'b0, 1'b0, lat, t, y, o, vn);
    n_chk++;
    if (y !== ye || o !== 1'b1) begin
      n_err++; $display("FAIL bound_max_plus1: got y=%0d ovf=%b want %0d 1", y, o, ye);
    end
  endtask

  task automatic test_gap_noise;
    int lat, t;
    logic signed [15:0] y;
    logic o, vn;
    bias = 16'sd0;
    for (int i = 0; i < 4; i++) begin g_x[i] = 16'sd256; g_w[i] = 16'sd256; end
    run_op(1'b0, 4, 2, 3, 1'b1, 1'b0, 1'b0, lat, t, y, o, vn);
    n_chk++;
    if (lat !== 1 || y !== 16'sd1024 || o !== 1'b0 || vn !== 1'b0) begin
      n_err++; $display("FAIL gap_noise: got lat=%0d y=%0d ovf=%b next_ov=%b want 1 1024 0 0", lat, y, o, vn);
    end
    n_chk++;
    if (busy4 !== 1'b0) begin n_err++; $display("FAIL gap_idle: got busy=%b want 0", busy4); end
  endtask

  task automatic test_abort_reset;
    int lat, t;
    logic signed [15:0] y;
    logic o, vn;
    bit seen;
    sel2 = 1'b0;
    bias = 16'sd0;
    start4 = 1'b1;
    tick();
    start4 = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; x = 16'sd256; w = 16'sd256;
      tick();
    end
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    n_chk++;
    if (busy4 !== 1'b0 || rdy4 !== 1'b0 || ov4 !== 1'b0 || y4 !== 16'sd0 || of4 !== 1'b0) begin
      n_err++; $display("FAIL abort_async: got busy=%b rdy=%b ov=%b y=%0d ovf=%b want all 0", busy4, rdy4, ov4, y4, of4);
    end
    #2 rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (ov4 === 1'b1 || busy4 === 1'b1) seen = 1'b1;
    end
    n_chk++;
    if (seen !== 1'b0) begin n_err++; $display("FAIL abort_no_pulse: got activity=%b want 0", seen); end
    for (int i = 0; i < 4; i++) begin g_x[i] = 16'sd256; g_w[i] = 16'sd512; end
    run_op(1'b0, 4, -1, 0, 1'b0, 1'b0, 1'b0, lat, t, y, o, vn);
    n_chk++;
    if (lat !== 1 || y !== 16'sd2048 || o !== 1'b0) begin
      n_err++; $display("FAIL abort_fresh: got lat=%0d y=%0d ovf=%b want 1 2048 0", lat, y, o);
    end
  endtask

  task automatic test_back_to_back;
    int lat_a, t_a, lat_b, t_b;
    logic signed [15:0] y_a, y_b;
    logic o_a, o_b, vn_a, vn_b;
    bias = 16'sd0;
    for (int i = 0; i < 4; i++) begin g_x[i] = 16'sd256; g_w[i] = 16'sd256; end
    run_op(1'b0, 4, -1, 0, 1'b0, 1'b0, 1'b1, lat_a, t_a, y_a, o_a, vn_a);
    for (int i = 0; i < 4; i++) begin g_x[i] = 16'sd256; g_w[i] = -16'sd256; end
    run_op(1'b0, 4, -1, 0, 1'b0, 1'b1, 1'b0, lat_b, t_b, y_b, o_b, vn_b);
    n_chk++;
    if (y_a !== 16'sd1024 || y_b !== -16'sd1024) begin
      n_err++; $display("FAIL b2b_results: got %0d %0d want 1024 -1024", y_a, y_b);
    end
    n_chk++;
    if (t_a < 0 || t_b - t_a !== 6) begin
      n_err++; $display("FAIL b2b_period: got %0d cycles want 6", t_b - t_a);
    end
  endtask

  initial begin
    rst_n = 1'b0; start4 = 1'b0; start2 = 1'b0; in_valid = 1'b0;
    x = '0; w = '0; bias = '0; sel2 = 1'b0;
    test_reset();
    test_basic();
    test_handshake();
    test_ovf_pos();
    test_floor();
    test_ovf_neg();
    test_boundary();
    test_gap_noise();
    test_abort_reset();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
